spi_cmd_parser: RTL and testbench
=================================

// Module: spi_cmd_parser
// PURPOSE
//  Downstream stage of the SPI receive path: consumes the AXI-Stream byte stream produced by the SPI
//  receiver (tlast marks end of frame) and decodes each frame into one register command for the CCU.
//  Frame = header byte {rw, addr[6:0]} followed, for writes, by DATA_BYTES little-endian data bytes.
//  Malformed frames are dropped and counted; only well-formed frames reach the command port.
// PARAMETERS
//  DATA_BYTES  4  payload bytes per write frame (>=1); cmd_wdata width = 8*DATA_BYTES
//  ADDR_W      7  register address width (<=7, taken from header bits [ADDR_W-1:0])
// PORTS
//  axi_aclk       in   1             single clock for the whole block
//  axi_areset     in   1             synchronous, active-high reset
//  s_axis_tdata   in   8             byte from SPI receiver
//  s_axis_tvalid  in   1             byte valid
//  s_axis_tready  out  1             parser can accept a byte
//  s_axis_tlast   in   1             last byte of frame
//  cmd_valid      out  1             decoded command available
//  cmd_ready      in   1             CCU accepts command
//  cmd_write      out  1             1 = write, 0 = read (header bit 7)
//  cmd_addr       out  ADDR_W        register address
//  cmd_wdata      out  8*DATA_BYTES  write data (0 for reads)
//  err_short      out  1             1-cycle pulse: frame ended before payload complete
//  err_long       out  1             1-cycle pulse: frame exceeded expected length
//  err_count      out  8             saturating count of dropped frames (short + long)
// BEHAVIOUR
//  - Reset (sync, active-high, wins over all): state=IDLE, s_axis_tready=0 in reset cycle, cmd_valid=0,
//    cmd_write=0, cmd_addr=0, cmd_wdata=0, err_short=err_long=0, err_count=0, byte counter=0.
//  - Beat accepted when s_axis_tvalid && s_axis_tready. All outputs registered.
//  - s_axis_tready = 1 in IDLE, DATA, DISCARD; 0 in ISSUE (backpressure while command pending).
//  - IDLE: on beat latch cmd_write=tdata[7], cmd_addr=tdata[ADDR_W-1:0], clear cmd_wdata, cnt=0.
//      read  & tlast  -> ISSUE
//      read  & !tlast -> DISCARD, err_long pulse, err_count++
//      write & tlast  -> IDLE,    err_short pulse, err_count++ (no command)
//      write & !tlast -> DATA
//  - DATA: on beat write tdata into cmd_wdata[8*cnt +: 8] (first payload byte = LSB), cnt++.
//      cnt==DATA_BYTES-1 & tlast  -> ISSUE
//      cnt==DATA_BYTES-1 & !tlast -> DISCARD, err_long pulse, err_count++
//      cnt< DATA_BYTES-1 & tlast  -> IDLE,    err_short pulse, err_count++
//  - DISCARD: accept and drop beats; on beat with tlast -> IDLE.
//  - ISSUE: cmd_valid=1; cmd_write/addr/wdata held stable; on cmd_ready -> IDLE, cmd_valid=0 next cycle.
//    cmd_valid must not drop without cmd_ready.
//  - Latency: cmd_valid rises the cycle after the final frame byte is accepted; ready same-cycle
//    acceptance allowed, next header accepted the cycle after cmd_ready handshake (1 bubble).
//  - err_count saturates at 8'hFF; err pulses exactly one cycle, never both in one cycle.
//  - tvalid low mid-frame: state held indefinitely, no timeout.
//  - Reset mid-frame or with cmd_valid high: command discarded, next accepted byte is a header.
//  - Unused header bits [6:ADDR_W] ignored.
// STRUCTURE
//  - Shared package: state encoding (IDLE/DATA/ISSUE/DISCARD), header field positions (RW_BIT=7),
//    error-counter width constant; reused by the future SPI transmit/response framer.
//  - Single flat module; cnt width $clog2(DATA_BYTES) (min 1). No sub-module needed.
// TESTING
//  - Write frame 8'h85,11,22,33,44(tlast) -> one cmd: write=1 addr=7'h05 wdata=32'h44332211.
//  - Read frame 8'h12(tlast) -> cmd: write=0 addr=7'h12 wdata=0; s_axis_tready=0 until cmd_ready.
//  - Short write 8'h81,AA,BB(tlast) -> no cmd, err_short 1 cycle, err_count=1; next frame decodes ok.
//  - Long write 8'h81,01,02,03,04,05,06(tlast) -> err_long at byte 04, bytes 05/06 dropped, no cmd.
//  - cmd_ready held low 10 cycles during ISSUE -> cmd fields stable, tready=0, no beats lost.
//  - 300 short frames -> err_count=8'hFF; axi_areset mid-DATA -> all outputs reset, next byte=header.

Source files
------------

// File: rtl/spi_cmd_parser_pkg.sv
// Shared definitions for the SPI command path: parser state encoding, header layout
// and error-counter width, also used by the SPI response framer.
package spi_cmd_parser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DATA    = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  localparam int RW_BIT    = 7;
  localparam int ERR_CNT_W = 8;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spi_cmd_parser.sv
// Decodes AXI-Stream byte frames from the SPI receiver into one register command each;
// malformed frames are dropped, flagged with a one-cycle pulse and counted.
module spi_cmd_parser
  import spi_cmd_parser_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_W     = 7
) (
  input  logic                    axi_aclk,
  input  logic                    axi_areset,
  input  logic [7:0]              s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic                    cmd_write,
  output logic [ADDR_W-1:0]       cmd_addr,
  output logic [8*DATA_BYTES-1:0] cmd_wdata,
  output logic                    err_short,
  output logic                    err_long,
  output logic [ERR_CNT_W-1:0]    err_count
);

  localparam int CNT_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BYTES - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    tready_q, tready_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic                    cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0]       cmd_addr_q, cmd_addr_d;
  logic [8*DATA_BYTES-1:0] cmd_wdata_q, cmd_wdata_d;
  logic                    err_short_q, err_short_d;
  logic                    err_long_q, err_long_d;
  logic [ERR_CNT_W-1:0]    err_count_q, err_count_d;
  logic                    beat;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    err_count_d = err_count_q;
    beat        = s_axis_tvalid && tready_q;

    case (state_q)
      ST_IDLE: begin
        if (beat) begin
          cmd_write_d = s_axis_tdata[RW_BIT];
          cmd_addr_d  = s_axis_tdata[ADDR_W-1:0];
          cmd_wdata_d = '0;
          cnt_d       = '0;
          if (!s_axis_tdata[RW_BIT]) begin
            if (s_axis_tlast) begin
              state_d = ST_ISSUE;
            end else begin
              state_d    = ST_DISCARD;
              err_long_d = 1'b1;
            end
          end else if (s_axis_tlast) begin
            err_short_d = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (beat) begin
          // Little-endian payload: byte cnt lands in lane cnt.
          for (int i = 0; i < DATA_BYTES; i++) begin
            if (cnt_q == CNT_W'(i)) cmd_wdata_d[8*i +: 8] = s_axis_tdata;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            if (s_axis_tlast) begin
              state_d = ST_ISSUE;
            end else begin
              state_d    = ST_DISCARD;
              err_long_d = 1'b1;
            end
          end else if (s_axis_tlast) begin
            state_d     = ST_IDLE;
            err_short_d = 1'b1;
          end
        end
      end
      ST_DISCARD: begin
        if (beat && s_axis_tlast) state_d = ST_IDLE;
      end
      ST_ISSUE: begin
        if (cmd_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (err_short_d || err_long_d) err_count_d = sat_inc(err_count_q);
    // Handshake outputs follow the next state so they stay registered.
    tready_d    = (state_d != ST_ISSUE);
    cmd_valid_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tready_q    <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tready_q    <= tready_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      err_count_q <= err_count_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign cmd_valid     = cmd_valid_q;
  assign cmd_write     = cmd_write_q;
  assign cmd_addr      = cmd_addr_q;
  assign cmd_wdata     = cmd_wdata_q;
  assign err_short     = err_short_q;
  assign err_long      = err_long_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_spi_cmd_parser.sv
// Randomised and directed frames against a frame-length reference model; commands
// and error pulses are scoreboarded as they appear.
module tb_spi_cmd_parser;

  localparam int DB = 4;
  localparam int AW = 7;
  localparam int WD = 8 * DB;

  logic          clk = 1'b0;
  logic          axi_areset;
  logic [7:0]    s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [WD-1:0] cmd_wdata;
  logic          err_short;
  logic          err_long;
  logic [7:0]    err_count;

  always #5 clk = ~clk;

  spi_cmd_parser #(.DATA_BYTES(DB), .ADDR_W(AW)) dut (
    .axi_aclk     (clk),
    .axi_areset   (axi_areset),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .err_short    (err_short),
    .err_long     (err_long),
    .err_count    (err_count)
  );

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [WD-1:0] d;
  } cmd_t;

  cmd_t exp_q[$];
  int   checks = 0, failures = 0;
  int   exp_short = 0, exp_long = 0, exp_errs = 0;
  int   n_short = 0, n_long = 0;
  int   rdy_mode = 0;      // 0 random, 1 held low, 2 held high
  bit   gaps_en = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a frame's fate depends only on its rw bit and its length.
  task automatic model_frame(input logic [7:0] f[$]);
    int   need;
    cmd_t c;
    need = f[0][7] ? 1 + DB : 1;
    if (f.size() == need) begin
      c.w = f[0][7];
      c.a = f[0][AW-1:0];
      c.d = '0;
      if (c.w) for (int k = 0; k < DB; k++) c.d = c.d | (WD'(f[1+k]) << (8 * k));
      exp_q.push_back(c);
    end else if (f.size() < need) begin
      exp_short++;
      exp_errs++;
    end else begin
      exp_long++;
      exp_errs++;
    end
  endtask

  // Called just after a negedge; returns just after the negedge following the beat.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    s_axis_tvalid = 1'b0;
    if (gaps_en) repeat ($urandom_range(0, 2)) @(negedge clk);
    s_axis_tdata  = b;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("tready_wait", 64'(n), 0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    model_frame(f);
    for (int i = 0; i < f.size(); i++) send_byte(f[i], i == f.size() - 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || cmd_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 0);
    repeat (3) @(negedge clk);
    check({tag, "_err_short"}, 64'(n_short), 64'(exp_short));
    check({tag, "_err_long"}, 64'(n_long), 64'(exp_long));
    check({tag, "_err_count"}, 64'(err_count), 64'((exp_errs > 255) ? 255 : exp_errs));
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_short = 0;
    exp_long  = 0;
    exp_errs  = 0;
    n_short   = 0;
    n_long    = 0;
  endtask

  // Command-side monitor: drives cmd_ready and scoreboards every presented command.
  initial begin
    bit pend = 1'b0;
    cmd_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (axi_areset) begin
        pend      = 1'b0;
        cmd_ready = 1'b0;
      end else begin
        if (err_short) n_short++;
        if (err_long) n_long++;
        if (err_short || err_long) check("err_exclusive", 64'(err_short & err_long), 0);
        if (pend) check("valid_held", 64'(cmd_valid), 1);
        if (cmd_valid) begin
          check("cmd_expected", 64'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            check("cmd_write", 64'(cmd_write), 64'(exp_q[0].w));
            check("cmd_addr", 64'(cmd_addr), 64'(exp_q[0].a));
            check("cmd_wdata", 64'(cmd_wdata), 64'(exp_q[0].d));
          end
        end
        case (rdy_mode)
          1:       cmd_ready = 1'b0;
          2:       cmd_ready = 1'b1;
          default: cmd_ready = 1'($urandom_range(0, 1));
        endcase
        if (cmd_valid && cmd_ready && exp_q.size() != 0) begin
          $display("cmd accepted: write=%0d addr=%02h wdata=%08h", cmd_write, cmd_addr, cmd_wdata);
          void'(exp_q.pop_front());
        end
        pend = cmd_valid && !cmd_ready;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, 64'(s_axis_tready), 0);
    check({tag, "_cmd_valid"}, 64'(cmd_valid), 0);
    check({tag, "_cmd_write"}, 64'(cmd_write), 0);
    check({tag, "_cmd_addr"}, 64'(cmd_addr), 0);
    check({tag, "_cmd_wdata"}, 64'(cmd_wdata), 0);
    check({tag, "_err_pulses"}, 64'({err_short, err_long}), 0);
    check({tag, "_err_count"}, 64'(err_count), 0);
  endtask

  initial begin
    logic [7:0] fr[$];
    int         len, kind;
    logic       rw;

    axi_areset    = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    axi_areset = 1'b0;

    fr = {8'h85, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(fr);
    drain("write_frame");

    // Read held in ISSUE with cmd_ready low: tready must stay low, no beats lost after.
    rdy_mode = 1;
    fr = {8'h12};
    send_frame(fr);
    for (int i = 0; i < 10; i++) begin
      check("issue_valid", 64'(cmd_valid), 1);
      check("issue_tready", 64'(s_axis_tready), 0);
      @(negedge clk);
    end
    rdy_mode = 2;
    fr = {8'h9A, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(fr);
    drain("read_hold");
    rdy_mode = 0;

    fr = {8'h81, 8'hAA, 8'hBB};
    send_frame(fr);
    drain("short_write");
    fr = {8'h83, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(fr);
    drain("after_short");

    fr = {8'h81, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_frame(fr);
    drain("long_write");
    fr = {8'h40, 8'h77};
    send_frame(fr);
    drain("long_read");

    for (int f = 0; f < 60; f++) begin
      rw   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      if (!rw) len = (kind < 7) ? 1 : $urandom_range(2, 3);
      else if (kind < 6) len = 1 + DB;
      else if (kind < 8) len = $urandom_range(1, DB);
      else len = $urandom_range(DB + 2, DB + 3);
      fr = {};
      fr.push_back({rw, 7'($urandom)});
      for (int k = 1; k < len; k++) fr.push_back(8'($urandom));
      send_frame(fr);
    end
    drain("random");

    // Reset in the middle of a write payload.
    send_byte(8'h85, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    axi_areset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid_data");
    model_reset();
    axi_areset = 1'b0;
    fr = {8'h86, 8'h55, 8'h66, 8'h77, 8'h88};
    send_frame(fr);
    drain("after_rst_data");

    // Reset while a command is pending.
    rdy_mode = 1;
    fr = {8'h33};
    send_frame(fr);
    @(negedge clk);
    axi_areset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_pending");
    model_reset();
    axi_areset = 1'b0;
    rdy_mode = 0;
    fr = {8'h21};
    send_frame(fr);
    drain("after_rst_cmd");

    gaps_en = 1'b0;
    for (int f = 0; f < 300; f++) begin
      fr = {8'h81};
      send_frame(fr);
    end
    drain("saturate");
    check("err_count_sat", 64'(err_count), 64'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
